// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package ssd_pkg;

    // Scan FSM: dark, anti-ghosting gap, digit lit
    typedef enum logic [1:0] {
        IDLE,
        GAP,
        ON
    } state_e;

    // Active-high segment pattern with every segment dark
    localparam logic [6:0] SEG_OFF = 7'b000_0000;

    // Active-high {g,f,e,d,c,b,a} patterns, entry 15 first so SEG_TABLE[n] is digit n
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-high seven-segment pattern.
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment driver: double-buffered digit data,
// per-slot anti-ghosting gap, registered pin outputs.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [6:0]              ssdCathode,
    output logic                    ssdDp,
    output logic [NUM_DIGITS-1:0]   ssdAnode,
    output logic                    frame_done,
    output logic                    updated
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic          POL      = (ACTIVE_LOW != 0);

    state_e                         state_q, state_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           frame_end;

    logic [NUM_DIGITS-1:0][3:0]     act_dig_q, shd_dig_q;
    logic [NUM_DIGITS-1:0]          act_dp_q, shd_dp_q, act_bl_q, shd_bl_q;
    logic                           pending_q, commit;

    logic [NUM_DIGITS-1:0]          anode_q, anode_hi;
    logic [6:0]                     cath_q, seg_dec, seg_hi;
    logic                           dp_q, dp_hi, frame_done_q, updated_q;
    logic                           lit;

    // Scan FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: cnt is the position inside the slot, spanning GAP and ON
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        frame_end = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = GAP;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                GAP: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == GAP_LAST) state_d = ON;
                end
                ON: begin
                    if (cnt_q == LAST_CNT) begin
                        state_d   = GAP;
                        cnt_d     = '0;
                        frame_end = (idx_q == LAST_IDX);
                        idx_d     = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Commit on the cycle the frame_done pin is high
    assign commit = frame_done_q && (load || pending_q);

    // Double buffer: shadow takes every load, active changes only on commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shd_dig_q <= '0;
            shd_dp_q  <= '0;
            shd_bl_q  <= '0;
            act_dig_q <= '0;
            act_dp_q  <= '0;
            act_bl_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            if (load) begin
                shd_dig_q <= digits_in;
                shd_dp_q  <= dp_in;
                shd_bl_q  <= blank_in;
            end
            if (commit) begin
                act_dig_q <= load ? digits_in : shd_dig_q;
                act_dp_q  <= load ? dp_in     : shd_dp_q;
                act_bl_q  <= load ? blank_in  : shd_bl_q;
                pending_q <= 1'b0;
            end else if (load) begin
                pending_q <= 1'b1;
            end
        end
    end

    ssd_hex_decoder u_dec (
        .nibble_i (act_dig_q[idx_q]),
        .seg_o    (seg_dec)
    );

    // Active-high pin values for the current state and digit
    always_comb begin
        lit      = enable && (state_q != IDLE) && !act_bl_q[idx_q];
        seg_hi   = lit ? seg_dec : SEG_OFF;
        dp_hi    = lit && (state_q == ON) && act_dp_q[idx_q];
        anode_hi = '0;
        if (lit && state_q == ON) anode_hi[idx_q] = 1'b1;
    end

    // Output registers, polarity applied here so reset lands on the dark level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anode_q      <= {NUM_DIGITS{POL}};
            cath_q       <= {7{POL}};
            dp_q         <= POL;
            frame_done_q <= 1'b0;
            updated_q    <= 1'b0;
        end else begin
            anode_q      <= anode_hi ^ {NUM_DIGITS{POL}};
            cath_q       <= seg_hi ^ {7{POL}};
            dp_q         <= dp_hi ^ POL;
            frame_done_q <= frame_end;
            updated_q    <= commit;
        end
    end

    assign ssdAnode   = anode_q;
    assign ssdCathode = cath_q;
    assign ssdDp      = dp_q;
    assign frame_done = frame_done_q;
    assign updated    = updated_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench: a frame-time reference model pushes the expected pins for
// each cycle; a monitor pops and compares on the falling clock edge.
module tb_ssd_scan_driver;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BL = 2;
    localparam int FR = N * RD;

    localparam logic [6:0] SEGTAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        int         tag;
        logic [3:0] an;
        logic [6:0] cat;
        logic       dp;
        logic       fd;
        logic       upd;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [6:0]  ssdCathode;
    logic        ssdDp;
    logic [3:0]  ssdAnode;
    logic        frame_done;
    logic        updated;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // reference model state
    bit          m_run = 0;
    int          m_t = 0;
    bit          m_fd = 0;
    bit          m_pend = 0;
    logic [15:0] m_dig = '0, s_dig = '0;
    logic [3:0]  m_dp = '0, s_dp = '0, m_bl = '0, s_bl = '0;

    ssd_scan_driver #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BL),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .ssdCathode (ssdCathode),
        .ssdDp      (ssdDp),
        .ssdAnode   (ssdAnode),
        .frame_done (frame_done),
        .updated    (updated)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_reset();
        m_run = 0; m_t = 0; m_fd = 0; m_pend = 0;
        m_dig = '0; s_dig = '0; m_dp = '0; s_dp = '0; m_bl = '0; s_bl = '0;
    endtask

    // Predict the pins for the next cycle from the current inputs, then advance
    task automatic tick();
        exp_t e;
        int d, p;
        e.tag = cyc + 1;
        e.an  = 4'hF;
        e.cat = 7'h7F;
        e.dp  = 1'b1;
        if (enable && m_run) begin
            d = (m_t / RD) % N;
            p = m_t % RD;
            if (!m_bl[d]) begin
                e.cat = ~SEGTAB[m_dig[d*4 +: 4]];
                if (p >= BL) begin
                    e.an = ~(4'b0001 << d);
                    e.dp = ~m_dp[d];
                end
            end
        end
        e.fd  = enable && m_run && (m_t == FR - 1);
        e.upd = m_fd && (load || m_pend);
        if (m_fd && load) begin
            m_dig = digits_in; m_dp = dp_in; m_bl = blank_in; m_pend = 0;
        end else if (m_fd && m_pend) begin
            m_dig = s_dig; m_dp = s_dp; m_bl = s_bl; m_pend = 0;
        end else if (load) begin
            m_pend = 1;
        end
        if (load) begin
            s_dig = digits_in; s_dp = dp_in; s_bl = blank_in;
        end
        m_fd = e.fd;
        if (!enable) begin
            m_run = 0; m_t = 0;
        end else if (!m_run) begin
            m_run = 1; m_t = 0;
        end else begin
            m_t = (m_t + 1) % FR;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        digits_in = d; dp_in = dp; blank_in = bl; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until_t(input int t);
        for (int i = 0; i < 4 * FR && !(m_run && m_t == t); i++) tick();
    endtask

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    // Monitor: reset values during reset, scoreboard entries otherwise
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or negedge reset);
            if (!reset) begin
                #1;
                cmp("rst_anode", 32'(ssdAnode), 32'hF);
                cmp("rst_cathode", 32'(ssdCathode), 32'h7F);
                cmp("rst_dp", 32'(ssdDp), 32'h1);
                cmp("rst_frame_done", 32'(frame_done), 32'h0);
                cmp("rst_updated", 32'(updated), 32'h0);
            end else if (q.size() > 0 && q[0].tag <= cyc) begin
                e = q.pop_front();
                cmp("tag", 32'(e.tag), 32'(cyc));
                cmp("anode", 32'(ssdAnode), 32'(e.an));
                cmp("cathode", 32'(ssdCathode), 32'(e.cat));
                cmp("dp", 32'(ssdDp), 32'(e.dp));
                cmp("frame_done", 32'(frame_done), 32'(e.fd));
                cmp("updated", 32'(updated), 32'(e.upd));
            end
        end
    end

    initial begin
        #1 reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // 0766 shown from the second frame on
        enable = 1'b1;
        ld(16'h0766, 4'h0, 4'h0);
        run(3 * FR);

        // mid-frame load held back until the boundary
        run_until_t(10);
        ld(16'h1234, 4'h0, 4'h0);
        run(2 * FR);

        // load on the frame_done cycle, then a second load in the same frame
        for (int i = 0; i < 2 * FR && !m_fd; i++) tick();
        ld(16'hA8F0, 4'h0, 4'h0);
        run_until_t(15);
        ld(16'h5C9B, 4'h0, 4'h0);
        run(3 * FR);

        // blank digit 1, decimal point on digit 0
        ld(16'hED76, 4'b0001, 4'b0010);
        run(3 * FR);

        // enable dropped in digit 2's ON phase, then restored
        run_until_t(2 * RD + 4);
        enable = 1'b0;
        run(5);
        enable = 1'b1;
        run(FR + 4);

        // randomized loads and enable drops
        for (int i = 0; i < 600; i++) begin
            enable    = ($urandom_range(0, 49) != 0);
            digits_in = 16'($urandom);
            dp_in     = 4'($urandom);
            blank_in  = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
            load      = ($urandom_range(0, 9) == 0);
            tick();
        end
        load = 1'b0;
        enable = 1'b1;
        run(2 * FR);

        // asynchronous reset in the middle of an ON phase
        for (int i = 0; i < 2 * FR && !(m_run && (m_t % RD) == 5 && !m_bl[(m_t / RD) % N]); i++) tick();
        #2 reset = 1'b0;
        q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        ld(16'hF00D, 4'b1000, 4'h0);
        run(2 * FR + 4);

        repeat (3) @(posedge clk);
        #1;
        cmp("queue_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Parametrised, time-multiplexed seven-segment display driver for 1–16 digits. It accepts a packed hex nibble vector plus per-digit decimal-point and blank masks through a load strobe. It double-buffers that data so updates land only on frame boundaries, and scans the anodes with an anti-ghosting blank gap. It sits between application logic (reaction timer, counters) and the board's `ssdCathode`/`ssdAnode` pins, and replaces per-design hard-coded anode case statements and divided-clock scan registers.

## Interface
- `NUM_DIGITS`, 8: number of digits/anodes scanned; legal range 1–16.
- `REFRESH_DIV`, 100_000: `clk` cycles per digit slot (1 kHz per digit at 100 MHz).
- `BLANK_CYCLES`, 16: cycles at the start of each slot during which all anodes are off; must be ≥1 and < `REFRESH_DIV`.
- `ACTIVE_LOW`, 1: 1 means anodes, cathodes and dp are driven active-low (Nexys4 DDR); 0 means active-high.
- `clk` in 1: single system clock; all logic runs in this domain, no derived clocks.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: scan enable; low means all digits dark.
- `load` in 1: single-cycle strobe that captures `digits_in`, `dp_in` and `blank_in`.
- `digits_in` in 4*NUM_DIGITS: nibble i drives digit i; hex 0–F.
- `dp_in` in NUM_DIGITS: decimal-point-on per digit.
- `blank_in` in NUM_DIGITS: 1 means the digit stays dark for its whole slot.
- `ssdCathode` out 7: segments {g,f,e,d,c,b,a}, bit 0 = a.
- `ssdDp` out 1: decimal point.
- `ssdAnode` out NUM_DIGITS: digit select; exactly one asserted in the ON phase, none otherwise.
- `frame_done` out 1: one-cycle pulse on the last cycle of the last digit's slot.
- `updated` out 1: one-cycle pulse when shadow data is committed to the active registers.

## Operation
- Storage: shadow registers, active registers, and a `pending` flag. `load` writes the shadow registers and sets `pending`.
- Multiple loads inside one frame: the last one wins.
- Commit happens at the frame boundary, i.e. the cycle `frame_done` is high. If `pending` is set, active ← shadow, `pending` clears and `updated` pulses on the next cycle.
- `load` coinciding with the boundary: the incoming inputs are committed directly, `updated` pulses and `pending` ends at 0.
- FSM states:
  - IDLE: anodes off. Leaves for GAP with digit index 0 when `enable` is high.
  - GAP: `BLANK_CYCLES` cycles, anodes off. Cathodes are already driven with the current digit's pattern. Moves to ON.
  - ON: `REFRESH_DIV`−`BLANK_CYCLES` cycles, with anode[idx] asserted unless `blank[idx]`. Then moves to GAP with idx+1, wrapping from `NUM_DIGITS`−1 to 0.
- `enable` low in any state: go to IDLE on the next edge. Digit index and prescaler reset to 0. Active and shadow data are kept.
- Blanked digit: the cathode and dp outputs show the inactive level and the anode stays off. Slot timing is unchanged.
- Encoding, active-high pattern, inverted when `ACTIVE_LOW`=1: 0→0111111, 6→1111101, 7→0000111, 8→1111111, A→1110111, F→1110001.

## Timing
- All outputs are registered: one cycle of latency from FSM state/index to pins.
- Reset values:
  - anodes, cathodes and dp at their inactive level (all 1s when `ACTIVE_LOW`).
  - `frame_done` 0 and `updated` 0.
  - FSM in IDLE, index 0, prescaler 0, `pending` 0.
  - active and shadow data 0.
- Reset asserted mid-frame forces all of these asynchronously, with no glitch to an asserted anode.
- Slot length is exactly `REFRESH_DIV` cycles. Frame length is `NUM_DIGITS`·`REFRESH_DIV` cycles.
- `NUM_DIGITS`=1: every slot is the last slot, so `frame_done` fires each slot.
- Prescaler width is $clog2(`REFRESH_DIV`). Index width is max(1, $clog2(`NUM_DIGITS`)).

## Structure
- Shared package `ssd_pkg`:
  - segment constant table for 0–F.
  - FSM state enum {IDLE, GAP, ON}.
  - `SEG_OFF` constant.
- Sub-module `ssd_hex_decoder`: combinational nibble→7-segment, active-high. It is instantiated once on the muxed active nibble; polarity inversion is done in the top.
- Everything else (prescaler, index counter, FSM, double buffer) lives in the top module.

## Test plan
All scenarios use `NUM_DIGITS`=4, `REFRESH_DIV`=8, `BLANK_CYCLES`=2, `ACTIVE_LOW`=1.
- Reset + enable, `digits_in`=0x0766 loaded → anodes 1110/1101/1011/0111 each low for 6 cycles after a 2-cycle 1111 gap; cathodes 0000010, 0000010, 1111000, 1000000.
- `load` of 0x1234 mid-frame → display keeps old data until `frame_done`; `updated` pulses the next cycle; digit 0 then shows "4".
- `load` on the `frame_done` cycle, then a second `load` later in the same frame → first value shown in the next frame, second in the following one.
- `blank_in`=0010, `dp_in`=0001 → anode 1101 never asserted; `ssdDp`=0 only during digit 0's ON phase.
- `enable` dropped in digit 2's ON phase → anodes 1111 one cycle later; on re-enable, digit 0's GAP starts.
- `reset` asserted asynchronously mid-ON → all outputs are at reset values immediately, before the next `clk` edge.
